pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/pipe_payload_reg.sv | 28 ++
 rtl/pipe_stage_reg.sv | 197 +++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the writeback pipeline stage register.
// Holds the payload struct (default widths), the stage-state enum and a
// small helper that maps a stage state to its held-entry count.
package pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_RD_W   = 5;

  // One beat travelling through the stage.
  typedef struct packed {
    logic                   reg_write;
    logic                   mem_to_reg;
    logic [PIPE_DATA_W-1:0] data;
    logic [PIPE_DATA_W-1:0] readdata;
    logic [PIPE_RD_W-1:0]   rd;
  } payload_t;

  // Number of entries held by the stage.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

  // Occupancy count reported for a given stage state.
  function automatic logic [1:0] state_occupancy(input stage_state_t s);
    logic [1:0] occ;
    case (s)
      ST_EMPTY: occ = 2'd0;
      ST_ONE:   occ = 2'd1;
      ST_FULL:  occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Enable-loaded payload register with synchronous active-high reset.
// Used for the head entry and, when the skid buffer is built, the skid entry.
module pipe_payload_reg #(
  parameter int W = 71
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_r;

  // Capture a new beat when loaded; clear on reset; otherwise hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_r <= {W{1'b0}};
    end else if (load_i) begin
      q_r <= d_i;
    end else begin
      q_r <= q_r;
    end
  end

  assign q_o = q_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Writeback pipeline stage register with valid/ready handshakes.
// Build option PIPE_STAGE_REG_SKID_EN: when defined, a second (skid) entry is
// added so ready_o is fully registered and never depends on ready_i. When
// undefined, a single entry is held and ready_o = !valid_o || ready_i.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int RD_W   = PIPE_RD_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              reg_write_i,
  input  logic              mem_to_reg_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] readdata_i,
  input  logic [RD_W-1:0]   rd_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              reg_write_o,
  output logic              mem_to_reg_o,
  output logic [DATA_W-1:0] data_o,
  output logic [DATA_W-1:0] readdata_o,
  output logic [RD_W-1:0]   rd_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [1:0]        occupancy_o
);

  // Flat payload layout, MSB first: reg_write, mem_to_reg, data, readdata, rd.
  localparam int PAY_W = 2 + 2 * DATA_W + RD_W;

  stage_state_t     state_r;
  stage_state_t     state_nxt_s;
  logic             valid_r;
  logic [1:0]       occ_r;
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic             head_load_s;
  logic [PAY_W-1:0] in_pay_s;
  logic [PAY_W-1:0] head_d_s;
  logic [PAY_W-1:0] head_q_s;

  assign in_pay_s   = {reg_write_i, mem_to_reg_i, data_i, readdata_i, rd_i};
  assign in_xfer_s  = valid_i & ready_o;
  assign out_xfer_s = valid_r & ready_i;

`ifdef PIPE_STAGE_REG_SKID_EN

  logic             ready_r;
  logic             skid_load_s;
  logic             head_from_skid_s;
  logic [PAY_W-1:0] skid_q_s;

  assign ready_o  = ready_r;
  assign head_d_s = head_from_skid_s ? skid_q_s : in_pay_s;

  // Next-state and entry-load decode for the two-entry stage.
  always_comb begin
    state_nxt_s      = state_r;
    head_load_s      = 1'b0;
    skid_load_s      = 1'b0;
    head_from_skid_s = 1'b0;
    if (flush_i) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            state_nxt_s = ST_ONE;
            head_load_s = 1'b1;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_xfer_s && out_xfer_s) begin
            state_nxt_s = ST_ONE;
            head_load_s = 1'b1;
          end else if (in_xfer_s) begin
            state_nxt_s = ST_FULL;
            skid_load_s = 1'b1;
          end else if (out_xfer_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_FULL: begin
          // ready_o is low here, so only the drain side can move.
          if (out_xfer_s) begin
            state_nxt_s      = ST_ONE;
            head_load_s      = 1'b1;
            head_from_skid_s = 1'b1;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Registered ready: accept whenever the next state leaves a free slot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_r <= 1'b1;
    end else begin
      ready_r <= (state_nxt_s != ST_FULL);
    end
  end

  pipe_payload_reg #(.W(PAY_W)) u_skid_reg (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (skid_load_s),
    .d_i    (in_pay_s),
    .q_o    (skid_q_s)
  );

`else

  assign ready_o  = !valid_r || ready_i;
  assign head_d_s = in_pay_s;

  // Next-state and head-load decode for the single-entry stage.
  always_comb begin
    state_nxt_s = state_r;
    head_load_s = 1'b0;
    if (flush_i) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            state_nxt_s = ST_ONE;
            head_load_s = 1'b1;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          // An accepted beat here implies ready_i, so the head is replaced.
          if (in_xfer_s) begin
            state_nxt_s = ST_ONE;
            head_load_s = 1'b1;
          end else if (out_xfer_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

`endif

  // Stage state plus its registered valid and occupancy decodes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_EMPTY;
      valid_r <= 1'b0;
      occ_r   <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      valid_r <= (state_nxt_s != ST_EMPTY);
      occ_r   <= state_occupancy(state_nxt_s);
    end
  end

  pipe_payload_reg #(.W(PAY_W)) u_head_reg (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (head_load_s),
    .d_i    (head_d_s),
    .q_o    (head_q_s)
  );

  assign valid_o      = valid_r;
  assign occupancy_o  = occ_r;
  assign mem_to_reg_o = head_q_s[PAY_W-2];
  assign data_o       = head_q_s[PAY_W-3 -: DATA_W];
  assign readdata_o   = head_q_s[RD_W +: DATA_W];
  assign rd_o         = head_q_s[RD_W-1:0];
  // Writes to register 0 are never signalled downstream.
  assign reg_write_o  = head_q_s[PAY_W-1] & valid_r & (|head_q_s[RD_W-1:0]);
  assign wb_data_o    = mem_to_reg_o ? readdata_o : data_o;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed literal scenarios plus
// randomized traffic compared every cycle against a queue-based model.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

`ifdef PIPE_STAGE_REG_SKID_EN
  localparam int CAP  = 2;
  localparam bit SKID = 1'b1;
`else
  localparam int CAP  = 1;
  localparam bit SKID = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, valid_i, ready_i;
  logic        reg_write_i, mem_to_reg_i;
  logic [31:0] data_i, readdata_i;
  logic [4:0]  rd_i;
  logic        ready_o, valid_o, reg_write_o, mem_to_reg_o;
  logic [31:0] data_o, readdata_o, wb_data_o;
  logic [4:0]  rd_o;
  logic [1:0]  occupancy_o;

  int n_checks = 0;
  int n_fail   = 0;
  payload_t mq[$];
  bit model_live = 1'b0;

  pipe_stage_reg dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .reg_write_i(reg_write_i), .mem_to_reg_i(mem_to_reg_i),
    .data_i(data_i), .readdata_i(readdata_i), .rd_i(rd_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o),
    .data_o(data_o), .readdata_o(readdata_o), .rd_o(rd_o),
    .wb_data_o(wb_data_o), .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // The stage may accept when it has a free slot; without skid it may also
  // accept into a full single entry when that entry drains this cycle.
  function automatic bit model_ready();
    if (SKID) return (mq.size() < CAP);
    return (mq.size() == 0) || (ready_i == 1'b1);
  endfunction

  // Reference model: FIFO of accepted beats, updated on every rising edge.
  always @(posedge clk_i) begin
    bit rdy, acc, pop;
    payload_t p;
    if (rst_i) begin
      mq.delete();
      model_live = 1'b1;
    end else if (flush_i) begin
      mq.delete();
    end else begin
      rdy = model_ready();
      acc = valid_i && rdy;
      pop = (mq.size() != 0) && ready_i;
      p.reg_write  = reg_write_i;
      p.mem_to_reg = mem_to_reg_i;
      p.data       = data_i;
      p.readdata   = readdata_i;
      p.rd         = rd_i;
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(p);
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk_i) begin
    if (model_live) begin
      chk("valid_o", valid_o, (mq.size() != 0));
      chk("ready_o", ready_o, model_ready());
      chk("occupancy_o", occupancy_o, mq.size());
      if (mq.size() != 0) begin
        chk("data_o", data_o, mq[0].data);
        chk("readdata_o", readdata_o, mq[0].readdata);
        chk("rd_o", rd_o, mq[0].rd);
        chk("mem_to_reg_o", mem_to_reg_o, mq[0].mem_to_reg);
        chk("reg_write_o", reg_write_o, mq[0].reg_write && (mq[0].rd != 5'd0));
        chk("wb_data_o", wb_data_o, mq[0].mem_to_reg ? mq[0].readdata : mq[0].data);
      end else begin
        chk("reg_write_o_idle", reg_write_o, 1'b0);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic beat(input logic v, input logic [31:0] d, input logic rdy);
    valid_i = v;
    data_i  = d;
    ready_i = rdy;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b1; ready_i = 1'b0;
    reg_write_i = 1'b1; mem_to_reg_i = 1'b1;
    data_i = 32'h1234_5678; readdata_i = 32'h9ABC_DEF0; rd_i = 5'd7;

    // Reset held two cycles with an incoming beat offered.
    step(); step();
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_occ", occupancy_o, 2'd0);
    chk("rst_data", data_o, 32'h0);
    chk("rst_readdata", readdata_o, 32'h0);
    chk("rst_rd", rd_o, 5'd0);
    chk("rst_regwrite", reg_write_o, 1'b0);
    chk("rst_memtoreg", mem_to_reg_o, 1'b0);
    chk("rst_wb", wb_data_o, 32'h0);
    rst_i = 1'b0;
    mem_to_reg_i = 1'b0; readdata_i = 32'h0;

    // Streaming with downstream always ready.
    beat(1'b1, 32'h1, 1'b1); step();
    chk("stream_d1", data_o, 32'h1); chk("stream_rdy1", ready_o, 1'b1);
    beat(1'b1, 32'h2, 1'b1); step();
    chk("stream_d2", data_o, 32'h2); chk("stream_rdy2", ready_o, 1'b1);
    beat(1'b1, 32'h3, 1'b1); step();
    chk("stream_d3", data_o, 32'h3); chk("stream_rdy3", ready_o, 1'b1);
    beat(1'b0, 32'h0, 1'b1); step();
    chk("stream_drained", valid_o, 1'b0);

`ifdef PIPE_STAGE_REG_SKID_EN
    // Backpressure: two beats accepted, third held upstream.
    beat(1'b1, 32'hA, 1'b0); step();
    chk("bp_a_head", data_o, 32'hA); chk("bp_rdy_one", ready_o, 1'b1);
    beat(1'b1, 32'hB, 1'b0); step();
    chk("bp_rdy_full", ready_o, 1'b0); chk("bp_occ2", occupancy_o, 2'd2);
    beat(1'b1, 32'hC, 1'b0); step();
    chk("bp_hold_a", data_o, 32'hA); chk("bp_still_full", occupancy_o, 2'd2);
    beat(1'b1, 32'hC, 1'b1); step();
    chk("bp_out_b", data_o, 32'hB);
    step();
    chk("bp_out_c", data_o, 32'hC); chk("bp_occ1", occupancy_o, 2'd1);
    beat(1'b0, 32'h0, 1'b1); step();
    chk("bp_empty", valid_o, 1'b0);
`else
    // Single entry: ready follows downstream when a beat is held.
    beat(1'b1, 32'h7, 1'b0); step();
    chk("ns_head7", data_o, 32'h7); chk("ns_rdy0", ready_o, 1'b0);
    beat(1'b1, 32'h8, 1'b1); #1;
    chk("ns_rdy_comb", ready_o, 1'b1);
    step();
    chk("ns_replace", data_o, 32'h8); chk("ns_occ1", occupancy_o, 2'd1);
    beat(1'b0, 32'h0, 1'b1); step();
    chk("ns_empty", valid_o, 1'b0);
`endif

    // Flush from the deepest occupancy, dropping a same-cycle beat.
    beat(1'b1, 32'h11, 1'b0); step();
    beat(1'b1, 32'h22, 1'b0); step();
    chk("fl_pre_occ", occupancy_o, CAP);
    flush_i = 1'b1; beat(1'b1, 32'h55, 1'b1); step();
    chk("fl_valid", valid_o, 1'b0); chk("fl_occ", occupancy_o, 2'd0);
    flush_i = 1'b0; beat(1'b0, 32'h0, 1'b1); step();
    chk("fl_no55", valid_o, 1'b0);

    // Writeback select and register-0 suppression.
    reg_write_i = 1'b1; mem_to_reg_i = 1'b1; readdata_i = 32'hDEAD; rd_i = 5'd0;
    beat(1'b1, 32'hBEEF, 1'b0); step();
    chk("wb_load", wb_data_o, 32'hDEAD); chk("wb_rd0", reg_write_o, 1'b0);
    rd_i = 5'd3; beat(1'b1, 32'hBEEF, 1'b1); step();
    chk("wb_rd3", reg_write_o, 1'b1); chk("wb_rd3_val", rd_o, 5'd3);
    mem_to_reg_i = 1'b0; beat(1'b1, 32'hBEEF, 1'b1); step();
    chk("wb_alu", wb_data_o, 32'hBEEF);
    beat(1'b0, 32'h0, 1'b0); step();

    // Reset mid-operation discards everything held.
    beat(1'b1, 32'h99, 1'b0); step();
    rst_i = 1'b1; step();
    chk("mrst_valid", valid_o, 1'b0); chk("mrst_data", data_o, 32'h0);
    chk("mrst_occ", occupancy_o, 2'd0);
    rst_i = 1'b0;

    // Randomized traffic checked by the compare process.
    for (int i = 0; i < 3000; i++) begin
      valid_i      = ($urandom_range(0, 9) < 7);
      ready_i      = ($urandom_range(0, 9) < 6);
      flush_i      = ($urandom_range(0, 99) < 3);
      rst_i        = ($urandom_range(0, 199) == 0);
      reg_write_i  = $urandom_range(0, 1);
      mem_to_reg_i = $urandom_range(0, 1);
      data_i       = $urandom;
      readdata_i   = $urandom;
      rd_i         = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
